hex_display_controller: RTL and testbench

//  Parametrised N-digit 7-segment display engine driving the board HEX outputs from one binary value.
//  Hex or decimal rendering; decimal uses a multicycle double-dabble FSM.

---
 rtl/hex_display_pkg.sv | 19 +
 rtl/hex_display_controller_seven_seg_decoder.sv | 17 +
 rtl/hex_display_controller.sv | 173 +++++++++++++++++
 tb/tb_hex_display_controller.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared types and segment constants for the hex display controller.
package hex_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_LOAD    = 2'd2
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Active-low segments {dp, g..a}; dp kept off here and applied by the decoder
    localparam logic [7:0] SEG_LUT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/hex_display_controller_seven_seg_decoder.sv
// Combinational nibble + decimal point to active-low 7-segment code.
module seven_seg_decoder
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg_c
);

    logic [7:0] lut_c;

    assign lut_c = SEG_LUT[nibble];
    // A blanked digit still shows its decimal point
    assign seg_c = {~dp, blank ? 7'h7F : lut_c[6:0]};

endmodule

// File: rtl/hex_display_controller.sv
// N-digit 7-segment display engine: hex or double-dabble decimal rendering,
// leading-zero blanking, decimal points, overflow dashes and global blink.
module hex_display_controller
    import hex_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned DATA_W     = 20,
    parameter int unsigned BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_mode,
    input  logic [NUM_DIGITS-1:0]   in_dp,
    input  logic                    in_blank_lz,
    input  logic                    blink_en,
    output logic [8*NUM_DIGITS-1:0] hex_out,
    output logic                    overflow
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned HEX_W = 8 * NUM_DIGITS;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    state_t                  state;
    logic [DATA_W-1:0]       shreg;
    logic [BCD_W-1:0]        bcd;
    logic [BCD_W-1:0]        bcd_adj_c;
    logic [CNT_W-1:0]        step;
    logic                    ovf_acc;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_blank_lz;

    logic [BCD_W-1:0]        digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    blank_lz;
    logic                    shown;

    logic [NUM_DIGITS-1:0]   blank_c;
    logic                    lead_c;
    logic [HEX_W-1:0]        seg_c;
    logic [HEX_W-1:0]        image_c;

    logic [BLK_W-1:0]        blink_cnt;
    logic                    phase;

    // Double-dabble correction: add 3 to every BCD digit >= 5 before the shift
    always_comb begin
        bcd_adj_c = bcd;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Control FSM, conversion datapath and displayed-digit register
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            in_ready      <= 1'b1;
            shreg         <= '0;
            bcd           <= '0;
            step          <= '0;
            ovf_acc       <= 1'b0;
            pend_dp       <= '0;
            pend_blank_lz <= 1'b0;
            digits        <= '0;
            dp            <= '0;
            blank_lz      <= 1'b0;
            shown         <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        if (in_mode) begin
                            shreg         <= in_data;
                            bcd           <= '0;
                            step          <= '0;
                            ovf_acc       <= 1'b0;
                            pend_dp       <= in_dp;
                            pend_blank_lz <= in_blank_lz;
                            state         <= ST_CONVERT;
                            in_ready      <= 1'b0;
                        end else begin
                            digits   <= BCD_W'(in_data);
                            dp       <= in_dp;
                            blank_lz <= in_blank_lz;
                            overflow <= 1'b0;
                            shown    <= 1'b1;
                        end
                    end
                end
                ST_CONVERT: begin
                    bcd     <= {bcd_adj_c[BCD_W-2:0], shreg[DATA_W-1]};
                    shreg   <= {shreg[DATA_W-2:0], 1'b0};
                    ovf_acc <= ovf_acc | bcd_adj_c[BCD_W-1];
                    step    <= step + CNT_W'(1);
                    if (step == CNT_W'(DATA_W - 1)) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    digits   <= bcd;
                    dp       <= pend_dp;
                    blank_lz <= pend_blank_lz;
                    overflow <= ovf_acc;
                    shown    <= 1'b1;
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Leading-zero blanking: digit i>0 blanks while it and every digit above are zero
    always_comb begin
        blank_c = '0;
        lead_c  = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
            lead_c     = lead_c && (digits[4*i +: 4] == 4'd0);
            blank_c[i] = blank_lz && lead_c;
        end
    end

    for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_dec
        seven_seg_decoder u_dec (
            .nibble (digits[4*g +: 4]),
            .dp     (dp[g]),
            .blank  (blank_c[g]),
            .seg_c  (seg_c[8*g +: 8])
        );
    end

    always_comb begin
        image_c = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (!shown) begin
                image_c[8*i +: 8] = SEG_BLANK;
            end else if (overflow) begin
                image_c[8*i +: 8] = SEG_DASH;
            end else begin
                image_c[8*i +: 8] = seg_c[8*i +: 8];
            end
        end
    end

    // Free-running blink divider and registered output mux
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
            hex_out   <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BLK_W'(1);
            end
            hex_out <= (blink_en && phase) ? {NUM_DIGITS{SEG_BLANK}} : image_c;
        end
    end

endmodule

// File: tb/tb_hex_display_controller.sv
// Directed self-checking bench for hex_display_controller (6 digits, 20-bit data, blink divider 4).
module tb_hex_display_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data;
    logic        in_mode;
    logic [5:0]  in_dp;
    logic        in_blank_lz;
    logic        blink_en;
    logic [47:0] hex_out;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    int lows;

    localparam logic [47:0] ALL_FF = 48'hFFFF_FFFF_FFFF;

    hex_display_controller #(
        .NUM_DIGITS (6),
        .DATA_W     (20),
        .BLINK_DIV  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_mode     (in_mode),
        .in_dp       (in_dp),
        .in_blank_lz (in_blank_lz),
        .blink_en    (blink_en),
        .hex_out     (hex_out),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic req(input logic mode, input logic [19:0] data, input logic [5:0] dpv,
                       input logic blz);
        in_valid    = 1'b1;
        in_mode     = mode;
        in_data     = data;
        in_dp       = dpv;
        in_blank_lz = blz;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (!in_ready && n < 40) begin
            n++;
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
        in_dp = '0; in_blank_lz = 1'b0; blink_en = 1'b0;

        // 1. reset
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_hex", hex_out, ALL_FF);
        chk("rst_ready", 48'(in_ready), 48'd1);
        chk("rst_ovf", 48'(overflow), 48'd0);

        // 2. hex 0x0ABCD, blanking
        req(1'b0, 20'h0ABCD, 6'b000000, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("hex_ready", 48'(in_ready), 48'd1);
        tick();
        chk("hex_abcd", hex_out, 48'hFFFF_8883_C6A1);

        // 3. decimal 123456 with dp on digit 2
        req(1'b1, 20'd123456, 6'b000100, 1'b1);
        tick();
        in_valid = 1'b0;
        count_busy(lows);
        chk("dec_busy", 48'(lows), 48'd21);
        chk("dec_hold_old", hex_out, 48'hFFFF_8883_C6A1);
        tick();
        chk("dec_123456", hex_out, 48'hF9A4_B019_9282);
        chk("dec_no_ovf", 48'(overflow), 48'd0);

        // 4. decimal overflow, producer holds a hex request while busy
        req(1'b1, 20'd1000000, 6'b111111, 1'b1);
        tick();
        req(1'b0, 20'h00001, 6'b000000, 1'b1);
        count_busy(lows);
        chk("ovf_busy", 48'(lows), 48'd21);
        chk("ovf_flag", 48'(overflow), 48'd1);
        tick();
        in_valid = 1'b0;
        chk("ovf_dash", hex_out, 48'hBFBF_BFBF_BFBF);
        chk("ovf_clear", 48'(overflow), 48'd0);
        tick();
        chk("hex_one", hex_out, 48'hFFFF_FFFF_FFF9);

        // small decimal with blanking
        req(1'b1, 20'd42, 6'b000000, 1'b1);
        tick();
        in_valid = 1'b0;
        count_busy(lows);
        tick();
        chk("dec_42", hex_out, 48'hFFFF_FFFF_99A4);

        // back-to-back hex: zero with dp on blanked digit, then unblanked 0xFFFFF
        req(1'b0, 20'h00000, 6'b100001, 1'b1);
        tick();
        req(1'b0, 20'hFFFFF, 6'b000000, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("b2b_zero", hex_out, 48'h7FFF_FFFF_FF40);
        tick();
        chk("b2b_fffff", hex_out, 48'hC08E_8E8E_8E8E);

        // 5. blink with divider 4, phase known from reset
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        req(1'b0, 20'h12345, 6'b000000, 1'b0);
        blink_en = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int e = 2; e <= 16; e++) begin
            tick();
            chk($sformatf("blink_e%0d", e), hex_out,
                (((e - 1) / 4) % 2 == 1) ? ALL_FF : 48'hC0F9_A4B0_9992);
        end
        blink_en = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            chk($sformatf("steady_%0d", e), hex_out, 48'hC0F9_A4B0_9992);
        end

        // 6. reset mid-conversion aborts
        req(1'b1, 20'd999999, 6'b000000, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_hex", hex_out, ALL_FF);
        chk("abort_ready", 48'(in_ready), 48'd1);
        chk("abort_ovf", 48'(overflow), 48'd0);
        repeat (25) tick();
        chk("abort_no_update", hex_out, ALL_FF);
        chk("abort_idle", 48'(in_ready), 48'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
